// File: rtl/ysyx_220053_pkg.sv
// Shared CPU package: datapath widths and the write-back result beat.
package ysyx_220053_pkg;

  localparam int unsigned CPU_ADDR_WIDTH = 5;
  localparam int unsigned CPU_DATA_WIDTH = 64;

  typedef struct packed {
    logic [CPU_ADDR_WIDTH-1:0] rd;
    logic [CPU_DATA_WIDTH-1:0] data;
  } wb_beat_t;

  localparam int unsigned WB_BEAT_WIDTH = $bits(wb_beat_t);

endpackage

// File: rtl/ysyx_220053_reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_220053_reg #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (wen) begin
      data_q <= din;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/ysyx_220053_scoreboard.sv
// Per-register busy bits: set on issue, cleared on register-file write; set wins a tie.
module ysyx_220053_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [ADDR_WIDTH-1:0]      set_addr,
  input  logic                       clr_en,
  input  logic [ADDR_WIDTH-1:0]      clr_addr,
  output logic [(1<<ADDR_WIDTH)-1:0] busy
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    // Applied after the clear so a same-cycle re-issue keeps the register busy.
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/ysyx_220053_wb_stage.sv
// Write-back stage: LSU/ALU result arbitration, registered RF write, scoreboard and bypass.
// Optional bypass path enabled by defining YSYX_220053_WB_BYPASS_EN.
module ysyx_220053_wb_stage
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs1_fwd_valid,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int unsigned WB_REG_WIDTH = 1 + WB_BEAT_WIDTH;

  wb_beat_t                  beat_d, beat_q;
  logic                      wen_d, wen_q;
  logic [WB_REG_WIDTH-1:0]   wb_reg_q;
  logic [(1<<ADDR_WIDTH)-1:0] busy;

  // LSU has fixed priority; it is always ready.
  assign lsu_ready = 1'b1;
  assign alu_ready = ~lsu_valid;

  always_comb begin
    beat_d = '0;
    wen_d  = 1'b0;
    if (lsu_valid) begin
      beat_d.rd   = CPU_ADDR_WIDTH'(lsu_rd);
      beat_d.data = CPU_DATA_WIDTH'(lsu_data);
      wen_d       = 1'b1;
    end else if (alu_valid) begin
      beat_d.rd   = CPU_ADDR_WIDTH'(alu_rd);
      beat_d.data = CPU_DATA_WIDTH'(alu_data);
      wen_d       = 1'b1;
    end
    // x0 writes are dropped here so rf_wen never fires for them.
    if (beat_d.rd == '0) begin
      wen_d = 1'b0;
    end
  end

  ysyx_220053_reg #(
    .WIDTH    (WB_REG_WIDTH),
    .RESET_VAL('0)
  ) u_wb_reg (
    .clk (clk),
    .rst (rst),
    .wen (1'b1),
    .din ({wen_d, beat_d}),
    .dout(wb_reg_q)
  );

  assign wen_q    = wb_reg_q[WB_REG_WIDTH-1];
  assign beat_q   = wb_reg_q[WB_BEAT_WIDTH-1:0];
  assign rf_wen   = wen_q;
  assign rf_waddr = ADDR_WIDTH'(beat_q.rd);
  assign rf_wdata = DATA_WIDTH'(beat_q.data);

  ysyx_220053_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid),
    .set_addr(iss_rd),
    .clr_en  (rf_wen),
    .clr_addr(rf_waddr),
    .busy    (busy)
  );

`ifdef YSYX_220053_WB_BYPASS_EN
  logic rs1_hit, rs2_hit;

  assign rs1_hit       = rf_wen && (rs1_addr == rf_waddr) && (rs1_addr != '0);
  assign rs2_hit       = rf_wen && (rs2_addr == rf_waddr) && (rs2_addr != '0);
  assign rs1_fwd_valid = rs1_hit;
  assign rs2_fwd_valid = rs2_hit;
  assign rs1_fwd_data  = rs1_hit ? rf_wdata : '0;
  assign rs2_fwd_data  = rs2_hit ? rf_wdata : '0;
  assign rs1_busy      = busy[rs1_addr] & ~rs1_hit;
  assign rs2_busy      = busy[rs2_addr] & ~rs2_hit;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
  assign rs1_busy      = busy[rs1_addr];
  assign rs2_busy      = busy[rs2_addr];
`endif

endmodule

// File: doc/ysyx_220053_wb_stage.md
YSYX_220053_WB_STAGE -- requirements
Module: ysyx_220053_wb_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning result data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports iss_valid  input  1 and iss_rd  input  ADDR_WIDTH: an instruction issued with destination iss_rd.
REQ-006 SHALL have ports lsu_valid  input  1, lsu_ready  output  1, lsu_rd  input  ADDR_WIDTH and lsu_data  input  DATA_WIDTH: load-result channel.
REQ-007 SHALL have ports alu_valid  input  1, alu_ready  output  1, alu_rd  input  ADDR_WIDTH and alu_data  input  DATA_WIDTH: ALU-result channel.
REQ-008 SHALL have ports rs1_addr and rs2_addr  input  ADDR_WIDTH, and rs1_busy and rs2_busy  output  1: source-operand hazard query.
REQ-009 SHALL have ports rs1_fwd_valid and rs2_fwd_valid  output  1, and rs1_fwd_data and rs2_fwd_data  output  DATA_WIDTH: bypass path.
REQ-010 SHALL have ports rf_wen  output  1, rf_waddr  output  ADDR_WIDTH and rf_wdata  output  DATA_WIDTH: register-file write port.

Function
REQ-011 SHALL accept a channel beat when valid and ready are both high at a rising clock edge.
REQ-012 SHALL drive lsu_ready constant 1 and alu_ready = !lsu_valid (fixed priority LSU over ALU).
REQ-013 SHALL register the accepted beat so that rf_wen/rf_waddr/rf_wdata are valid the cycle after acceptance (latency 1).
REQ-014 SHALL drive rf_wen 0 for any cycle with no accepted beat in the previous cycle, and for beats whose rd is 0.
REQ-015 SHALL keep 2^ADDR_WIDTH busy bits; bit 0 is hardwired 0.
REQ-016 SHALL set busy[iss_rd] at the edge where iss_valid=1 and iss_rd!=0.
REQ-017 SHALL clear busy[rf_waddr] at the edge ending a cycle with rf_wen=1.
REQ-018 SHALL let set win when set and clear target the same register in the same cycle.
REQ-019 SHALL treat iss_valid to an already-busy rd as a protocol violation; busy stays 1, no error output.
REQ-020 SHALL compute rsN_busy combinationally as busy[rsN_addr] masked by a bypass hit (REQ-022).
REQ-021 SHALL not check result rd against busy; a result for a non-busy rd is written normally.

Configuration
REQ-022 SHALL, with YSYX_220053_WB_BYPASS_EN defined, assert rsN_fwd_valid and drive rsN_fwd_data=rf_wdata when rf_wen=1, rsN_addr==rf_waddr and rsN_addr!=0, and force rsN_busy=0 in that cycle.
REQ-023 SHALL, with YSYX_220053_WB_BYPASS_EN undefined, tie rsN_fwd_valid and rsN_fwd_data to 0; rsN_busy falls only the cycle after the write.

Reset
REQ-024 SHALL, with rst=1 at an edge, clear all busy bits and rf_wen to 0; rf_waddr and rf_wdata reset to 0.
REQ-025 SHALL discard any beat presented during reset; lsu_ready and alu_ready follow REQ-012 regardless of rst.
REQ-026 SHALL resume normal acceptance the first edge after rst deasserts.

Structure
REQ-027 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and the result-beat struct (rd, data) from the shared CPU package.
REQ-028 SHALL implement the output register with the team's existing enable/reset register module; busy bits live in one sub-module ysyx_220053_scoreboard.

Verification
REQ-029 SHALL cover: iss rd=5, then alu rd=5 data=0x1234 -> rf_wen=1 waddr=5 wdata=0x1234 next cycle, busy[5] 0 after.
REQ-030 SHALL cover: lsu_valid and alu_valid same cycle -> alu_ready=0, LSU written first, ALU beat written one cycle later.
REQ-031 SHALL cover: alu rd=0 data=0xFF -> rf_wen stays 0, busy unchanged.
REQ-032 SHALL cover: iss rd=7 in the same cycle rf writes rd=7 -> busy[7]=1 after edge.
REQ-033 SHALL cover: BYPASS_EN, rf writes rd=3 data=0xAB with rs1_addr=3 -> rs1_fwd_valid=1, rs1_fwd_data=0xAB, rs1_busy=0; without macro rs1_busy=1 that cycle.
REQ-034 SHALL cover: rst asserted with busy[9]=1 and a beat pending -> busy all 0, rf_wen=0 next cycle.
